dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory controller for the MEM stage of the MIPS pipeline. It is a word-organised RAM with byte, half and full-width access sizes, and extends loads to full width as signed or unsigned. It has a registered one-cycle load path with a valid strobe. Partial stores run as a two-cycle read-modify-write with a ready handshake, so the array needs no native byte enables.

## Interface
Parameters:
- DWIDTH, 32: data word width; multiple of 32 (32 or 64).
- AWIDTH, 10: byte-address width.
- DEPTH, 2**(AWIDTH-log2(DWIDTH/8)): number of words.

Ports:
- m_clk  in  1  clock; all state changes on rising edge.
- m_rst  in  1  reset; synchronous, active-low.
- m_i_ce  in  1  access request.
- m_wr_en  in  1  1 = store, 0 = load; sampled with m_i_ce.
- m_i_size  in  2  0 = byte, 1 = half, 2 = 32-bit word, 3 = full DWIDTH.
- m_i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- m_i_addr  in  AWIDTH  byte address.
- m_i_store_data  in  DWIDTH  store datum, right-justified.
- m_o_ready  out  1  request can be accepted this cycle.
- m_o_valid  out  1  one-cycle pulse: m_o_load_data holds a new load result.
- m_o_load_data  out  DWIDTH  extended load result.
- m_o_misalign  out  1  one-cycle pulse: the accepted access was misaligned.

## Operation
- Acceptance: a request is accepted when m_i_ce and m_o_ready are both 1 at a rising edge. While m_o_ready is 0, m_i_ce is ignored and the requester holds the request.
- Word index is m_i_addr[AWIDTH-1:log2(DWIDTH/8)], modulo DEPTH. Byte offset is the low log2(DWIDTH/8) bits.
- The lane mask comes from size and offset: 1, 2, 4 or DWIDTH/8 consecutive lanes starting at the offset.
- Load: selected lanes are shifted to bit 0 and extended per m_i_unsigned. Size 3 returns the whole word.
- Full-width store (size 3 aligned, or size 2 when DWIDTH = 32): the word is written at the accepting edge. The FSM stays in IDLE.
- Partial store: at the accepting edge, address, shifted data and mask are latched and the FSM goes IDLE -> MERGE. In MERGE, the current word is merged lane-by-lane with the latched data, written at the next edge, and the FSM returns to IDLE.
- Store data is shifted left by offset*8 before merging.
- Reset, including mid-MERGE: FSM to IDLE, any pending merge is discarded, word i is set to i, m_o_load_data = 0, m_o_valid = 0, m_o_misalign = 0.

## Timing
- m_o_ready = (state == IDLE), combinational from state.
- Load accepted at edge T: m_o_valid = 1 and data valid after T, held until the next load completes. Latency is 1.
- Full store: 1 cycle. Partial store: 2 cycles, with m_o_ready low during the MERGE cycle.
- A load accepted in the cycle after a store completes returns the new data, with no forwarding hazard.
- Back-to-back loads sustain 1 per cycle. A load cannot be accepted during MERGE.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned means offset not a multiple of the access size in bytes.
  - A misaligned access asserts m_o_misalign for one cycle after acceptance.
  - A misaligned store is suppressed: no write, no MERGE.
  - A misaligned load returns 0 with m_o_valid = 1.
- Not defined:
  - Offset bits below the size alignment are forced to 0, so the access is truncated to aligned.
  - m_o_misalign is tied to 0.

## Test plan
- Reset then loads: with m_rst low for 1 cycle, then load word at addr 0x10 (size 2) -> m_o_valid pulses next cycle, m_o_load_data = 0x00000004.
- Byte store RMW: store 0xAB size 0 at addr 0x11 -> m_o_ready low for 1 cycle; a subsequent word load of 0x10 returns 0x0000AB04.
- Sign extension: after the above, load size 0 at 0x11 with unsigned = 0 -> 0xFFFFFFAB; with unsigned = 1 -> 0x000000AB.
- Half store 0x8001 at 0x12, then signed half load at 0x12 -> 0xFFFF8001; word at 0x10 = 0x8001AB04.
- Misalign with DMEM_MISALIGN_TRAP_EN: word store 0xDEADBEEF at 0x13 -> m_o_misalign pulses, word 0x10 unchanged. Without the macro -> word 0x10 = 0xDEADBEEF.
- Reset asserted during MERGE of a byte store to 0x20 -> word 8 reads 0x00000008 after reset, and m_o_ready is 1 on the first cycle out of reset.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic              m_i_ce;
  logic              m_wr_en;
  logic [1:0]        m_i_size;
  logic              m_i_unsigned;
  logic [AWIDTH-1:0] m_i_addr;
  logic [DWIDTH-1:0] m_i_store_data;
  logic              m_o_ready;
  logic              m_o_valid;
  logic [DWIDTH-1:0] m_o_load_data;
  logic              m_o_misalign;

  modport master (
    output m_i_ce, m_wr_en, m_i_size, m_i_unsigned, m_i_addr, m_i_store_data,
    input  m_o_ready, m_o_valid, m_o_load_data, m_o_misalign
  );

  modport slave (
    input  m_i_ce, m_wr_en, m_i_size, m_i_unsigned, m_i_addr, m_i_store_data,
    output m_o_ready, m_o_valid, m_o_load_data, m_o_misalign
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MIPS MEM-stage data memory: byte/half/word/full loads with extension, partial stores via RMW.
// Optional macro DMEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating to aligned.
module dmem_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 2 ** (AWIDTH - $clog2(DWIDTH / 8))
) (
  input  logic       m_clk,
  input  logic       m_rst,
  dmem_ctrl_if.slave bus
);
  localparam int NB   = DWIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t            state;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [IDXW-1:0]   pend_idx;
  logic [DWIDTH-1:0] pend_data;
  logic [NB-1:0]     pend_mask;
  logic [DWIDTH-1:0] load_data_q;
  logic              valid_q;
  logic              misalign_q;

  logic              ready;
  logic              accept;
  logic [OFFW-1:0]   offset;
  logic [OFFW-1:0]   align_mask;
  logic [OFFW-1:0]   eff_off;
  logic [OFFW+2:0]   bit_shift;
  logic [IDXW-1:0]   widx;
  logic [NB-1:0]     lane_mask;
  logic              misaligned;
  int                nbytes;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] rd_shift;
  logic [DWIDTH-1:0] ld_ext;
  logic [DWIDTH-1:0] st_shift;
  logic [DWIDTH-1:0] merged;

  assign ready  = (state == IDLE);
  assign accept = bus.m_i_ce & ready;

  assign bus.m_o_ready     = ready;
  assign bus.m_o_valid     = valid_q;
  assign bus.m_o_load_data = load_data_q;
  assign bus.m_o_misalign  = misalign_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    nbytes = NB;
    case (bus.m_i_size)
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      2'd2:    nbytes = 4;
      default: nbytes = NB;
    endcase

    offset     = bus.m_i_addr[OFFW-1:0];
    align_mask = OFFW'(nbytes - 1);
    eff_off    = offset & ~align_mask;
    bit_shift  = {eff_off, 3'b000};
    widx       = IDXW'(int'(bus.m_i_addr[AWIDTH-1:OFFW]) % DEPTH);

`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = |(offset & align_mask);
`else
    misaligned = 1'b0;
`endif

    lane_mask = '0;
    for (int b = 0; b < NB; b++)
      lane_mask[b] = (b >= int'(eff_off)) && (b < int'(eff_off) + nbytes);

    rd_word  = mem[widx];
    rd_shift = rd_word >> bit_shift;
    ld_ext   = '0;
    for (int i = 0; i < DWIDTH; i++)
      ld_ext[i] = (i < nbytes * 8) ? rd_shift[i]
                                   : (~bus.m_i_unsigned & rd_shift[nbytes*8-1]);

    st_shift = bus.m_i_store_data << bit_shift;

    // Lanes outside the latched mask keep the word's current contents.
    merged = mem[pend_idx];
    for (int b = 0; b < NB; b++)
      if (pend_mask[b]) merged[b*8 +: 8] = pend_data[b*8 +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge m_clk) begin
    if (!m_rst) begin
      state       <= IDLE;
      load_data_q <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      pend_idx    <= '0;
      pend_data   <= '0;
      pend_mask   <= '0;
      // NOTE: the array is reset on purpose (word i holds i), so it maps to flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= DWIDTH'(i);
    end else begin
      valid_q    <= 1'b0;
      misalign_q <= accept & misaligned;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!bus.m_wr_en) begin
              valid_q     <= 1'b1;
              load_data_q <= misaligned ? '0 : ld_ext;
            end else if (!misaligned) begin
              if (&lane_mask) begin
                mem[widx] <= st_shift;
              end else begin
                pend_idx  <= widx;
                pend_data <= st_shift;
                pend_mask <= lane_mask;
                state     <= MERGE;
              end
            end
          end
        end
        MERGE: begin
          mem[pend_idx] <= merged;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DWIDTH=32, AWIDTH=10); expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  dmem_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .m_clk(clk),
    .m_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [1:0] size, input logic uns,
                     input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.m_i_ce         = 1'b1;
    bus.m_wr_en        = wr;
    bus.m_i_size       = size;
    bus.m_i_unsigned   = uns;
    bus.m_i_addr       = addr;
    bus.m_i_store_data = data;
    step();
    bus.m_i_ce = 1'b0;
  endtask

  task automatic load(input logic [1:0] size, input logic uns, input logic [AW-1:0] addr);
    req(1'b0, size, uns, addr, '0);
  endtask

  task automatic store(input logic [1:0] size, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req(1'b1, size, 1'b0, addr, data);
  endtask

  initial begin
    bus.m_i_ce         = 1'b0;
    bus.m_wr_en        = 1'b0;
    bus.m_i_size       = 2'd0;
    bus.m_i_unsigned   = 1'b0;
    bus.m_i_addr       = '0;
    bus.m_i_store_data = '0;

    // Reset state
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check("rst_ready", bus.m_o_ready, 1);
    check("rst_valid", bus.m_o_valid, 0);
    check("rst_data", bus.m_o_load_data, 0);
    check("rst_misalign", bus.m_o_misalign, 0);

    // Initial contents: word 4 holds 4
    load(2'd2, 1'b0, 10'h010);
    check("ld_init_valid", bus.m_o_valid, 1);
    check("ld_init_data", bus.m_o_load_data, 32'h0000_0004);
    step();
    check("valid_pulse", bus.m_o_valid, 0);
    check("data_held", bus.m_o_load_data, 32'h0000_0004);

    // Byte store RMW
    store(2'd0, 10'h011, 32'h0000_00AB);
    check("byte_st_busy", bus.m_o_ready, 0);
    step();
    check("byte_st_done", bus.m_o_ready, 1);
    load(2'd2, 1'b0, 10'h010);
    check("ld_after_byte", bus.m_o_load_data, 32'h0000_AB04);

    // Sign / zero extension
    load(2'd0, 1'b0, 10'h011);
    check("byte_signed", bus.m_o_load_data, 32'hFFFF_FFAB);
    load(2'd0, 1'b1, 10'h011);
    check("byte_unsigned", bus.m_o_load_data, 32'h0000_00AB);

    // Half store then loads
    store(2'd1, 10'h012, 32'h0000_8001);
    check("half_st_busy", bus.m_o_ready, 0);
    step();
    load(2'd1, 1'b0, 10'h012);
    check("half_signed", bus.m_o_load_data, 32'hFFFF_8001);
    load(2'd2, 1'b0, 10'h010);
    check("word_after_half", bus.m_o_load_data, 32'h8001_AB04);

    // Misaligned word store
    store(2'd2, 10'h013, 32'hDEAD_BEEF);
    check("mis_st_flag", bus.m_o_misalign, TRAP ? 1 : 0);
    check("mis_st_ready", bus.m_o_ready, 1);
    load(2'd2, 1'b0, 10'h010);
    check("mis_st_word", bus.m_o_load_data, TRAP ? 32'h8001_AB04 : 32'hDEAD_BEEF);
    check("aligned_ld_flag", bus.m_o_misalign, 0);

    // Misaligned half load
    load(2'd1, 1'b0, 10'h011);
    check("mis_ld_valid", bus.m_o_valid, 1);
    check("mis_ld_flag", bus.m_o_misalign, TRAP ? 1 : 0);
    check("mis_ld_data", bus.m_o_load_data, TRAP ? 32'h0000_0000 : 32'hFFFF_BEEF);

    // Top byte unsigned, full-width load
    load(2'd0, 1'b1, 10'h013);
    check("byte3_unsigned", bus.m_o_load_data, TRAP ? 32'h0000_0080 : 32'h0000_00DE);
    load(2'd3, 1'b0, 10'h010);
    check("full_load", bus.m_o_load_data, TRAP ? 32'h8001_AB04 : 32'hDEAD_BEEF);

    // Back-to-back loads
    load(2'd2, 1'b0, 10'h000);
    check("b2b0_valid", bus.m_o_valid, 1);
    check("b2b0_data", bus.m_o_load_data, 32'h0000_0000);
    load(2'd2, 1'b0, 10'h004);
    check("b2b1_valid", bus.m_o_valid, 1);
    check("b2b1_data", bus.m_o_load_data, 32'h0000_0001);

    // Load held during MERGE is ignored until ready returns
    store(2'd0, 10'h005, 32'h0000_0077);
    check("merge_busy", bus.m_o_ready, 0);
    bus.m_i_ce       = 1'b1;
    bus.m_wr_en      = 1'b0;
    bus.m_i_size     = 2'd2;
    bus.m_i_unsigned = 1'b0;
    bus.m_i_addr     = 10'h004;
    step();
    check("merge_ld_ignored", bus.m_o_valid, 0);
    step();
    bus.m_i_ce = 1'b0;
    check("held_ld_valid", bus.m_o_valid, 1);
    check("held_ld_data", bus.m_o_load_data, 32'h0000_7701);

    // Reset asserted mid-MERGE
    store(2'd0, 10'h020, 32'h0000_0055);
    check("pre_rst_busy", bus.m_o_ready, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("post_rst_ready", bus.m_o_ready, 1);
    check("post_rst_data", bus.m_o_load_data, 0);
    load(2'd2, 1'b0, 10'h020);
    check("merge_discarded", bus.m_o_load_data, 32'h0000_0008);
    load(2'd2, 1'b0, 10'h010);
    check("mem_reinit", bus.m_o_load_data, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
